// File: rtl/audio_sample_source_if.sv
// Audio sample source bus: per-channel tone controls in, sample words plus strobe out.
// The master side is the sample source. The slave side drives the controls and
// consumes the samples. BIT_WIDTH must be at least 2.
interface audio_sample_source_if #(
  parameter int CHANNELS  = 2,
  parameter int BIT_WIDTH = 16,
  localparam int SW       = $clog2(BIT_WIDTH)
);
  logic [CHANNELS*BIT_WIDTH-1:0] phase_step;
  logic [CHANNELS*2-1:0]         wave_mode;
  logic [CHANNELS*SW-1:0]        atten_shift;
  logic                          sample_valid;
  logic [CHANNELS*BIT_WIDTH-1:0] audio_sample_word;

  modport master (
    input  phase_step,
    input  wave_mode,
    input  atten_shift,
    output sample_valid,
    output audio_sample_word
  );

  modport slave (
    output phase_step,
    output wave_mode,
    output atten_shift,
    input  sample_valid,
    input  audio_sample_word
  );
endinterface

// File: rtl/audio_sample_source.sv
// Audio sample source.
// A fractional accumulator derives a SAMPLE_RATE strobe from clk_pixel. Its
// average rate is exact, and the integer interval between strobes varies.
// On every strobe, each channel's phase accumulator is shaped into a
// saw, square or triangle wave, or muted. The result is arithmetically
// attenuated and registered as a signed sample. The phase then advances.
module audio_sample_source #(
  parameter int CLK_RATE    = 74_250_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int CHANNELS    = 2,
  parameter int BIT_WIDTH   = 16,
  localparam int SW         = $clog2(BIT_WIDTH),
  localparam int ACC_WIDTH  = $clog2(CLK_RATE + SAMPLE_RATE) + 1
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic enable,
  audio_sample_source_if.master bus
);

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_MUTE     = 2'd3
  } wave_e;

  localparam logic [ACC_WIDTH-1:0] CLK_RATE_A    = ACC_WIDTH'(CLK_RATE);
  localparam logic [ACC_WIDTH-1:0] SAMPLE_RATE_A = ACC_WIDTH'(SAMPLE_RATE);

  logic [ACC_WIDTH-1:0]          acc;
  logic [ACC_WIDTH-1:0]          sum;
  logic                          tick;
  logic [BIT_WIDTH-1:0]          phase [CHANNELS];
  logic [CHANNELS*BIT_WIDTH-1:0] word_next;

  // Map one phase value to an attenuated signed sample.
  function automatic logic [BIT_WIDTH-1:0] render(
    input logic [BIT_WIDTH-1:0] p,
    input wave_e                mode,
    input logic [SW-1:0]        shift
  );
    logic [BIT_WIDTH-1:0] t;
    logic [BIT_WIDTH-1:0] shaped;
    logic [SW-1:0]        amt;
    logic                 msb;
    msb    = p[BIT_WIDTH-1];
    t      = msb ? ~(p << 1) : (p << 1);
    shaped = '0;
    unique case (mode)
      WAVE_SAW:      shaped = {~msb, p[BIT_WIDTH-2:0]};
      WAVE_SQUARE:   shaped = {msb, {(BIT_WIDTH-1){~msb}}};
      WAVE_TRIANGLE: shaped = {~t[BIT_WIDTH-1], t[BIT_WIDTH-2:0]};
      WAVE_MUTE:     shaped = '0;
    endcase
    // An out-of-range shift saturates, so the sample collapses to 0 or -1.
    amt = (int'(shift) > BIT_WIDTH - 1) ? SW'(BIT_WIDTH - 1) : shift;
    return BIT_WIDTH'($signed(shaped) >>> amt);
  endfunction

  // Rate strobe: tick when the accumulated sample rate crosses one clock period.
  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum  = acc + SAMPLE_RATE_A;
    tick = enable && (sum >= CLK_RATE_A);
  end

  // Next sample words, computed from the pre-increment phases and the live controls.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      word_next[k*BIT_WIDTH +: BIT_WIDTH] = render(phase[k],
                                                   wave_e'(bus.wave_mode[k*2 +: 2]),
                                                   bus.atten_shift[k*SW +: SW]);
    end
  end

  // Fractional rate accumulator. It freezes while enable is low.
  // NOTE: state registers use non-blocking assignments, so every block samples pre-edge values.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      acc <= tick ? (sum - CLK_RATE_A) : sum;
    end
  end

  // Per-channel phase accumulators. They advance only on strobes and wrap silently.
  // NOTE: this small register array is reset explicitly, because a restart must begin from phase 0.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) phase[k] <= '0;
    end else if (tick) begin
      for (int k = 0; k < CHANNELS; k++) begin
        phase[k] <= phase[k] + bus.phase_step[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Registered outputs: a one-cycle strobe, and sample words held between strobes.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bus.sample_valid      <= 1'b0;
      bus.audio_sample_word <= '0;
    end else begin
      bus.sample_valid <= tick;
      if (tick) bus.audio_sample_word <= word_next;
    end
  end

endmodule

// File: tb/tb_audio_sample_source.sv
// Testbench for audio_sample_source at CLK_RATE=10 and SAMPLE_RATE=3 with two 16-bit channels.
// The reference model predicts a strobe on enabled cycle n whenever floor(n*SR/CR) steps up.
// It computes samples from the waveform definitions with plain integer arithmetic.
module tb_audio_sample_source;

  localparam int CR   = 10;
  localparam int SR   = 3;
  localparam int CH   = 2;
  localparam int BW   = 16;
  localparam int SW   = $clog2(BW);
  localparam int HALF = 1 << (BW - 1);
  localparam int FULL = 1 << BW;

  logic clk_pixel = 1'b0;
  logic reset;
  logic enable;

  audio_sample_source_if #(.CHANNELS(CH), .BIT_WIDTH(BW)) bus ();

  audio_sample_source #(
    .CLK_RATE(CR), .SAMPLE_RATE(SR), .CHANNELS(CH), .BIT_WIDTH(BW)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          en_cnt   = 0;
  int          ph [CH];
  logic        exp_valid;
  logic [15:0] exp_word [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tick_at(input int n);
    return ((n * SR) / CR) != (((n - 1) * SR) / CR);
  endfunction

  function automatic int shape_ref(input int p, input int mode);
    int t;
    case (mode)
      0: return p - HALF;
      1: return (p < HALF) ? HALF - 1 : -HALF;
      2: begin
        t = (p < HALF) ? 2 * p : 2 * FULL - 1 - 2 * p;
        return t - HALF;
      end
      default: return 0;
    endcase
  endfunction

  task automatic set_ch(input int k, input int mode, input int step, input int shift);
    bus.wave_mode[k*2 +: 2]     = 2'(mode);
    bus.phase_step[k*BW +: BW]  = 16'(step);
    bus.atten_shift[k*SW +: SW] = SW'(shift);
  endtask

  function automatic logic [15:0] word_of(input int k);
    return bus.audio_sample_word[k*BW +: BW];
  endfunction

  // Advance one clock. The model is updated from the inputs seen at the edge,
  // and every output is then compared just after the edge.
  task automatic cycle();
    int sh;
    int v;
    if (reset) begin
      en_cnt    = 0;
      exp_valid = 1'b0;
      for (int k = 0; k < CH; k++) begin
        ph[k]       = 0;
        exp_word[k] = '0;
      end
    end else if (enable) begin
      en_cnt++;
      exp_valid = tick_at(en_cnt);
      if (exp_valid) begin
        for (int k = 0; k < CH; k++) begin
          sh = int'(bus.atten_shift[k*SW +: SW]);
          if (sh > BW - 1) sh = BW - 1;
          v = shape_ref(ph[k], int'(bus.wave_mode[k*2 +: 2])) >>> sh;
          exp_word[k] = 16'(v);
          ph[k] = (ph[k] + int'(bus.phase_step[k*BW +: BW])) % FULL;
        end
      end
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk_pixel);
    #1;
    if (reset) cyc = 0; else cyc++;
    check("model_valid", 32'(bus.sample_valid), 32'(exp_valid));
    for (int k = 0; k < CH; k++) check($sformatf("model_word%0d", k), 32'(word_of(k)), 32'(exp_word[k]));
  endtask

  task automatic wait_tick(output int at_cyc);
    bit found;
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 3 * CR && !found; i++) begin
      cycle();
      if (bus.sample_valid) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!found) check("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t;
    int strobes;
    int exp_cyc [6] = '{4, 7, 10, 14, 17, 20};
    logic [15:0] hold;

    reset  = 1'b1;
    enable = 1'b0;
    set_ch(0, 0, 'h1000, 0);
    set_ch(1, 1, 'h4000, 9);
    repeat (2) cycle();
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_word", bus.audio_sample_word, 32'd0);

    // Strobe cadence, saw ramp and attenuated square.
    reset  = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 18; k++) begin
      wait_tick(t);
      if (k < 6) check($sformatf("strobe_cyc%0d", k), 32'(t), 32'(exp_cyc[k]));
      check($sformatf("saw_seq%0d", k), 32'(word_of(0)), 32'(16'(32'h8000 + k * 32'h1000)));
      check($sformatf("square_seq%0d", k), 32'(word_of(1)), (k % 4 < 2) ? 32'h003F : 32'hFFC0);
    end
    check("tick_density", 32'(t), 32'd60);

    // Mid-period control change: the output holds until the next strobe.
    hold = word_of(0);
    set_ch(0, 2, 'h0800, 2);
    cycle();
    check("hold_between", 32'(word_of(0)), 32'(hold));
    wait_tick(t);
    check("mid_change_tri", 32'(word_of(0)), 32'hF000);
    check("ch1_unaffected", 32'(word_of(1)), 32'hFFC0);

    // Drop enable exactly when a strobe is due, then hold it low for 500 cycles.
    for (int i = 0; i < CR && !tick_at(en_cnt + 1); i++) cycle();
    enable = 1'b0;
    cycle();
    check("en_low_same_cycle", 32'(bus.sample_valid), 32'd0);
    strobes = 0;
    repeat (499) begin
      cycle();
      strobes += int'(bus.sample_valid);
    end
    check("en_low_no_strobe", 32'(strobes), 32'd0);
    enable = 1'b1;
    cycle();
    check("resume_tick", 32'(bus.sample_valid), 32'd1);

    // Randomised controls and enable, checked cycle by cycle against the model.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        set_ch(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, BW - 1)));
      end
      enable = ($urandom_range(0, 7) != 0);
      cycle();
    end

    // Reset mid-period with nonzero phases.
    enable = 1'b1;
    set_ch(0, 0, 'h1234, 0);
    wait_tick(t);
    cycle();
    reset = 1'b1;
    cycle();
    check("midrst_valid", 32'(bus.sample_valid), 32'd0);
    check("midrst_word", bus.audio_sample_word, 32'd0);
    reset = 1'b0;
    set_ch(0, 0, 'h1000, 0);
    set_ch(1, 1, 'h4000, 0);
    wait_tick(t);
    check("post_rst_latency", 32'(t), 32'd4);
    check("post_rst_saw0", 32'(word_of(0)), 32'h8000);
    check("post_rst_square0", 32'(word_of(1)), 32'h7FFF);

    // Mute keeps advancing the phase. Saw then resumes at the advanced phase.
    set_ch(0, 3, 'h1000, 0);
    for (int k = 0; k < 3; k++) begin
      wait_tick(t);
      check($sformatf("mute_zero%0d", k), 32'(word_of(0)), 32'd0);
    end
    set_ch(0, 0, 'h1000, 0);
    wait_tick(t);
    check("mute_resume", 32'(word_of(0)), 32'hC000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
